// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle of ID/EX operand, producer-stage and scoreboard signals for the
// forwarding/hazard controller; master drives the pipeline side.
interface fwd_hazard_ctrl_if #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int CNTW    = 32
);
    localparam int SELW = $clog2(NUM_STG + 1);

    logic [NUM_SRC*AW-1:0]   ex_rs;
    logic [NUM_STG-1:0]      stg_wr;
    logic [NUM_STG*AW-1:0]   stg_rd;
    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    id_valid;
    logic [NUM_SRC*AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]      id_rs_used;
    logic [AW-1:0]           id_rd;
    logic                    id_is_long;
    logic                    ex_valid;
    logic                    ex_is_load;
    logic [AW-1:0]           ex_rd;
    logic                    long_done;
    logic [AW-1:0]           long_done_rd;
    logic                    stall_id;
    logic [2**AW-1:0]        sb_pending;
    logic [CNTW-1:0]         stall_count;

    modport master (
        output ex_rs, stg_wr, stg_rd, id_valid, id_rs, id_rs_used, id_rd,
               id_is_long, ex_valid, ex_is_load, ex_rd, long_done, long_done_rd,
        input  fwd_sel, stall_id, sb_pending, stall_count
    );

    modport slave (
        input  ex_rs, stg_wr, stg_rd, id_valid, id_rs, id_rs_used, id_rd,
               id_is_long, ex_valid, ex_is_load, ex_rd, long_done, long_done_rd,
        output fwd_sel, stall_id, sb_pending, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding select, long-op register scoreboard and ID stall
// generation with a saturating stall-cycle counter.
module fwd_hazard_ctrl #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_ctrl_if.slave   bus
);
    localparam int SELW = $clog2(NUM_STG + 1);
    localparam int NREG = 2**AW;

    logic [NREG-1:0]    sb_pending_reg;
    logic [NREG-1:0]    sb_pending_next;
    logic [NREG-1:0]    set_vec;
    logic [NREG-1:0]    clr_vec;
    logic [CNTW-1:0]    stall_count_reg;
    logic [NUM_SRC-1:0] luse_src;
    logic [NUM_SRC-1:0] raw_src;
    logic               luse;
    logic               raw;
    logic               waw;
    logic               stall;
    logic               issue;
    logic               complete;

    // Scan from oldest to youngest so the youngest matching stage overrides.
    function automatic logic [SELW-1:0] fwd_pick(
        input logic [NUM_STG-1:0]    wr,
        input logic [NUM_STG*AW-1:0] rd,
        input logic [AW-1:0]         rs
    );
        fwd_pick = '0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (wr[k] && rd[k*AW +: AW] != '0 && rd[k*AW +: AW] == rs)
                fwd_pick = SELW'(k + 1);
        end
    endfunction

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign bus.fwd_sel[gi*SELW +: SELW] =
            fwd_pick(bus.stg_wr, bus.stg_rd, bus.ex_rs[gi*AW +: AW]);
        assign luse_src[gi] = bus.id_rs_used[gi] &&
                              bus.id_rs[gi*AW +: AW] == bus.ex_rd;
        assign raw_src[gi]  = bus.id_rs_used[gi] &&
                              bus.id_rs[gi*AW +: AW] != '0 &&
                              sb_pending_reg[bus.id_rs[gi*AW +: AW]];
    end

    assign luse  = bus.id_valid && bus.ex_valid && bus.ex_is_load &&
                   bus.ex_rd != '0 && (|luse_src);
    assign raw   = bus.id_valid && (|raw_src);
    assign waw   = bus.id_valid && bus.id_is_long && bus.id_rd != '0 &&
                   sb_pending_reg[bus.id_rd];
    assign stall = luse | raw | waw;

    assign issue    = bus.id_valid && bus.id_is_long && !stall && bus.id_rd != '0;
    assign complete = bus.long_done && bus.long_done_rd != '0;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        assign set_vec[gi] = issue    && bus.id_rd        == AW'(gi);
        assign clr_vec[gi] = complete && bus.long_done_rd == AW'(gi);
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        sb_pending_next    = (sb_pending_reg & ~clr_vec) | set_vec;
        sb_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_pending_reg  <= '0;
            stall_count_reg <= '0;
        end else begin
            sb_pending_reg <= sb_pending_next;
            if (stall && stall_count_reg != {CNTW{1'b1}})
                stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign bus.stall_id    = stall;
    assign bus.sb_pending  = sb_pending_reg;
    assign bus.stall_count = stall_count_reg;
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Next-generation operand forwarding and hazard controller for the pipelined RISC-V core.
- Generalises EX-stage forwarding to a parametrised number of source operands and producer stages.
- Adds a register scoreboard that tracks in-flight long-latency operations (div/mul) and drives an ID-stage stall for load-use, long-op RAW and long-op WAW hazards.
- Keeps a saturating stall-cycle performance counter.
- Sits between the ID/EX pipeline registers and the EX operand muxes; `stall_id` feeds PC/IF_ID hold logic.

Parameters:
- AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- NUM_STG, 2, forwarding producer stages; index 0 is youngest (EX_MEM), index 1 is MEM_WB, and so on.
- SELW, $clog2(NUM_STG+1), width of each forward select field (derived, not overridable).
- CNTW, 32, stall counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- ex_rs  in  NUM_SRC*AW  source regs of instruction in EX; operand s at [s*AW +: AW]
- stg_wr  in  NUM_STG  producer stage k writes a register and its result is available
- stg_rd  in  NUM_STG*AW  destination reg of stage k
- fwd_sel  out  NUM_SRC*SELW  per operand: 0 = regfile, k+1 = forward from stage k
- id_valid  in  1  valid instruction in ID
- id_rs  in  NUM_SRC*AW  ID source regs
- id_rs_used  in  NUM_SRC  operand s is actually read
- id_rd  in  AW  ID destination
- id_is_long  in  1  ID instruction is long-latency and writes id_rd
- ex_valid  in  1  valid instruction in EX
- ex_is_load  in  1  EX instruction is a load with regwrite
- ex_rd  in  AW  EX destination
- long_done  in  1  long-latency unit writes back this cycle
- long_done_rd  in  AW  register written by long_done
- stall_id  out  1  hold ID/IF, inject bubble into EX
- sb_pending  out  2**AW  scoreboard; bit r means reg r is pending
- stall_count  out  CNTW  stall cycles counted

Behaviour:
- Forwarding (combinational):
  - fwd_sel[s] = k+1 for the lowest k with stg_wr[k] && stg_rd[k]!=0 && stg_rd[k]==ex_rs[s]; otherwise 0.
  - The youngest stage wins on a multi-match.
  - ex_rs[s]==0 always yields 0.
- Load-use hazard:
  - luse = id_valid && ex_valid && ex_is_load && ex_rd!=0 && some s has id_rs_used[s] && id_rs[s]==ex_rd.
- Scoreboard RAW hazard:
  - raw = id_valid && some s has id_rs_used[s] && id_rs[s]!=0 && sb_pending[id_rs[s]].
- Scoreboard WAW hazard:
  - waw = id_valid && id_is_long && id_rd!=0 && sb_pending[id_rd].
- stall_id = luse | raw | waw.
  - Combinational from the registered scoreboard and current inputs.
  - A long_done in the same cycle does not remove the stall; the stall lifts the following cycle.
- Scoreboard update (registered, every rising clk):
  - Issue: id_valid && id_is_long && !stall_id && id_rd!=0 sets bit id_rd.
  - Completion: long_done && long_done_rd!=0 clears bit long_done_rd.
  - Set and clear of the same bit in one cycle: set wins. This is unreachable via WAW but is still defined.
  - Bit 0 is constant 0.
- Forwarding from long units: by the time long_done fires, the producer is in stage 0. Its result is forwarded only through stg_wr/stg_rd; this block does not forward from long_done.
- Stall counter: increments by 1 each cycle with stall_id==1 and saturates at all-ones. There is no wrap.
- Reset (rst_n==0 at a rising clk):
  - sb_pending clears to 0 and stall_count to 0, taking effect the next cycle, with priority over same-cycle set/clear and increment.
  - Combinational outputs still follow their inputs.
  - A reset mid long-op drops all pending bits; a later long_done for a dropped reg is a harmless clear.
- Latency:
  - fwd_sel and stall_id: 0 cycles.
  - Scoreboard effects: visible 1 cycle after issue or completion.

Test Plan:
- Forward priority: stg_wr=2'b11, stg_rd={x5,x5}, ex_rs0=x5 -> fwd_sel0=1. With stg_wr=2'b10 -> 2. With ex_rs0=x0 and stg_rd=x0 -> 0.
- Load-use: EX has a load to x7; ID has id_rs1=x7 used -> stall_id=1 for exactly one cycle, and stall_count goes 0->1. The same case with id_rs_used1=0 -> stall_id=0.
- Long RAW: issue div to x9 at cycle T -> sb_pending[9]=1 at T+1. An ID reader of x9 stalls until the cycle after long_done_rd=x9, with stall_count increasing by the number of stalled cycles.
- WAW plus same-cycle done: x9 pending, ID long to x9 with long_done_rd=x9 the same cycle -> stall that cycle. The next cycle issues, and sb_pending[9]=1 again.
- Saturation and reset: CNTW=4, stall held 20 cycles -> stall_count=15 and stays there. rst_n=0 for one clk with x3/x4 pending -> sb_pending=0, stall_count=0.
- x0 handling: long issue to x0 and an EX load to x0 with ID reading x0 -> no scoreboard bit set and stall_id=0.
